mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
Memory/IO responder on the far end of the CPU byte bus (mem_a, mem_dout, mem_wr in; mem_din, io_buffer_full out).
- Models 128 KB byte-wide RAM with 1-cycle read latency and single-cycle writes.
- Decodes the IO window mem_a[17:16]==2'b11: UART TX/RX byte FIFOs, cycle counter, program-stop.
- Serves as the simulation/FPGA-side counterpart of the cpu top level.

Parameters:
RAM_ADDR_W, 17, byte address width of RAM (2^17 = 128 KB)
TX_DEPTH_LOG, 3, log2 of TX FIFO depth (8 entries)
RX_DEPTH_LOG, 3, log2 of RX FIFO depth (8 entries)
FULL_MARGIN, 2, io_buffer_full asserts when TX free slots <= FULL_MARGIN

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
mem_a  input  32  byte address from CPU; only [17:0] decoded
mem_dout  input  8  write data from CPU
mem_wr  input  1  1 = write, 0 = read
mem_din  output  8  read data to CPU, valid the cycle after the read request
io_buffer_full  output  1  TX FIFO near full; CPU must not issue a 0x30000 write
tx_valid  output  1  TX FIFO head valid toward UART
tx_data  output  8  TX FIFO head byte
tx_ready  input  1  UART accepts head this cycle (pop when tx_valid & tx_ready)
rx_valid  input  1  UART delivers byte this cycle
rx_data  input  8  received byte
program_stop  output  1  sticky; set by a write to 0x30004
tx_overflow  output  1  sticky; a TX write was dropped because the FIFO was full

Behaviour:
- Reset (rst_in=1 at a clock edge):
  - Outputs: mem_din=0, tx_valid=0, io_buffer_full=0, program_stop=0, tx_overflow=0.
  - State: both FIFOs empty, cycle counter = 0, counter snapshot = 0.
  - RAM contents are not cleared.
  - Reset mid-operation discards any pending read data and all FIFO contents.
- Decode on mem_a[17:16]:
  - 2'b00 or 2'b01: RAM, index mem_a[RAM_ADDR_W-1:0].
  - 2'b10: unmapped. Reads return 0; writes are dropped.
  - 2'b11: IO, selected by mem_a[2:0]. Only offsets 0 and 4..7 are defined; other offsets read 0 and drop writes.
- RAM:
  - Write stores mem_dout at the edge.
  - Read registers ram[addr] into mem_din at the edge, so data is visible the next cycle.
  - Back-to-back reads give one byte per cycle.
  - Read-after-write to the same address on the next cycle returns the new byte.
- mem_din is updated every cycle, with the registered result of the current cycle's read. On a write cycle it holds 0. The CPU samples only after its own reads.
- IO write 0x30000:
  - mem_dout==0x00: ignored.
  - Otherwise push to the TX FIFO.
  - If the FIFO is full, drop the byte and set tx_overflow.
- IO read 0x30000: pop the RX FIFO head into mem_din next cycle; if empty, return 0x00 with no pop.
- IO read 0x30004..0x30007: counter bytes, little-endian.
  - Reading 0x30004 returns counter[7:0] and latches counter[31:8] into the snapshot in the same edge.
  - 0x30005, 0x30006 and 0x30007 return snapshot bytes 0, 1 and 2, so a 4-byte read is coherent.
- IO write 0x30004: sets program_stop (sticky until reset).
- Cycle counter: 32-bit, increments every non-reset cycle, wraps at 2^32.
- RX FIFO:
  - Pushes on rx_valid.
  - When full, the incoming byte is dropped.
  - Simultaneous push and pop on a full FIFO: pop the head, push the new byte.
- TX FIFO:
  - Simultaneous push (CPU) and pop (UART) on a full FIFO is accepted with no overflow.
  - On an empty FIFO, the pushed byte appears on tx_valid the following cycle (no bypass).
- io_buffer_full is registered from the post-edge count: 1 when count >= 2^TX_DEPTH_LOG - FULL_MARGIN. The margin covers the 1-cycle flag latency plus one in-flight write.
- Pointers are TX_DEPTH_LOG / RX_DEPTH_LOG bits wide plus one extra wrap bit. Full means equal indices with differing wrap bits.

Decomposition:
- Shared config header constants: IO_BASE_HI (2'b11), IO_UART_OFS (3'd0), IO_CLK_OFS (3'd4), RAM_SIZE.
- One natural sub-module, byte_fifo, parameterised by depth log:
  - Ports: push/pop/din/dout/empty/full/count; synchronous active-high reset.
  - Instantiated twice, once for TX and once for RX.
- RAM array, counter and decode live in the top module.

Test Plan:
- RAM round-trip: write 0x5A at 0x00010, then read 0x00010 next cycle -> mem_din=0x5A one cycle after the read; read 0x00011 (never written after init pattern) -> init byte.
- UART TX: write 0x41, then 0x00, then 0x42 to 0x30000 with tx_ready=1 -> tx_data shows 0x41 then 0x42; 0x00 never appears.
- TX full with tx_ready=0: 6 writes -> io_buffer_full=1 after the 6th edge; 8 writes succeed; 9th write -> tx_overflow=1 and FIFO holds the first 8 bytes.
- RX: read 0x30000 with FIFO empty -> 0x00; then rx_valid with 0x37, read -> 0x37; read again -> 0x00.
- Counter: release reset, wait 300 cycles, read 0x30004..0x30007 consecutively -> bytes assemble to the counter value at the 0x30004 read edge (e.g. 0x0000012C ± fixed offset), upper bytes unchanged by later increments.
- Stop and reset: write 0x30004 -> program_stop=1 next cycle; assert rst_in mid TX burst -> program_stop=0, tx_valid=0, counter restarts from 0.

Source files
------------

// File: rtl/mem_io_responder_pkg.sv
// Shared address-map constants and region decode for the CPU-side memory/IO responder.
package mem_io_responder_pkg;

    localparam logic [1:0] IO_BASE_HI  = 2'b11;
    localparam logic [2:0] IO_UART_OFS = 3'd0;
    localparam logic [2:0] IO_CLK_OFS  = 3'd4;
    localparam int         RAM_SIZE    = 1 << 17;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_NONE,
        REGION_IO
    } region_e;

    // Regions 00 and 01 together form the 128 KB RAM; 10 is a hole.
    function automatic region_e decode_region(input logic [1:0] hi);
        if (hi == IO_BASE_HI) return REGION_IO;
        if (hi[1])            return REGION_NONE;
        return REGION_RAM;
    endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte FIFO with wrap-bit pointers; a pop frees room for a push in the same cycle.
module byte_fifo #(
    parameter int DEPTH_LOG = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic               empty,
    output logic               full,
    output logic [DEPTH_LOG:0] count
);

    localparam int DEPTH = 1 << DEPTH_LOG;

    logic [7:0]         mem [DEPTH];
    logic [DEPTH_LOG:0] wr_ptr;
    logic [DEPTH_LOG:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG-1:0] == rd_ptr[DEPTH_LOG-1:0]) &&
                     (wr_ptr[DEPTH_LOG] != rd_ptr[DEPTH_LOG]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[DEPTH_LOG-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG-1:0]] <= din;
    end

endmodule

// File: rtl/mem_io_responder.sv
// Far-end responder for the CPU byte bus: 128 KB RAM, UART TX/RX FIFOs,
// cycle counter with coherent snapshot, and the program-stop flag.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_W   = $clog2(RAM_SIZE),
    parameter int TX_DEPTH_LOG = 3,
    parameter int RX_DEPTH_LOG = 3,
    parameter int FULL_MARGIN  = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        program_stop,
    output logic        tx_overflow
);

    localparam int RAM_DEPTH = 1 << RAM_ADDR_W;
    localparam int TX_DEPTH  = 1 << TX_DEPTH_LOG;
    localparam logic [TX_DEPTH_LOG:0] TX_FULL_THRESH =
        (TX_DEPTH_LOG + 1)'(TX_DEPTH - FULL_MARGIN);

    region_e     region;
    logic [2:0]  io_ofs;
    logic        is_rd;
    logic        is_io;
    logic        ram_wr;
    logic        tx_push_req;
    logic        tx_push_acc;
    logic        tx_pop;
    logic        tx_empty;
    logic        tx_full;
    logic [TX_DEPTH_LOG:0] tx_count;
    logic [TX_DEPTH_LOG:0] tx_next_count;
    logic        rx_pop;
    logic        rx_empty;
    logic        rx_full;
    logic [7:0]  rx_dout;
    logic [RX_DEPTH_LOG:0] rx_count;
    logic        stop_wr;
    logic        clk_lo_rd;
    logic [31:0] cycle_cnt;
    logic [23:0] snap;
    logic [7:0]  io_rd_data;
    logic [7:0]  ram [RAM_DEPTH];
    logic [7:0]  ram_q;
    logic        ram_sel_q;
    logic [7:0]  io_q;
    logic        unused_bits;

    assign region = decode_region(mem_a[17:16]);
    assign io_ofs = mem_a[2:0];
    assign is_rd  = !mem_wr;
    assign is_io  = (region == REGION_IO);

    assign ram_wr      = mem_wr && (region == REGION_RAM) && !rst_in;
    assign stop_wr     = mem_wr && is_io && (io_ofs == IO_CLK_OFS);
    assign tx_push_req = mem_wr && is_io && (io_ofs == IO_UART_OFS) && (mem_dout != 8'h00);
    assign rx_pop      = is_rd && is_io && (io_ofs == IO_UART_OFS);
    assign clk_lo_rd   = is_rd && is_io && (io_ofs == IO_CLK_OFS);

    // UART handshake: a byte moves only on a cycle where valid and ready are both high.
    assign tx_valid    = !tx_empty;
    assign tx_pop      = tx_valid && tx_ready;
    assign tx_push_acc = tx_push_req && (!tx_full || tx_pop);
    assign tx_next_count = tx_count + {{TX_DEPTH_LOG{1'b0}}, tx_push_acc}
                                    - {{TX_DEPTH_LOG{1'b0}}, tx_pop};

    byte_fifo #(.DEPTH_LOG(TX_DEPTH_LOG)) u_tx_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (tx_push_req),
        .pop   (tx_pop),
        .din   (mem_dout),
        .dout  (tx_data),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_count)
    );

    byte_fifo #(.DEPTH_LOG(RX_DEPTH_LOG)) u_rx_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (rx_valid),
        .pop   (rx_pop),
        .din   (rx_data),
        .dout  (rx_dout),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count)
    );

    always_ff @(posedge clk_in) begin
        if (ram_wr) ram[mem_a[RAM_ADDR_W-1:0]] <= mem_dout;
        ram_q <= ram[mem_a[RAM_ADDR_W-1:0]];
    end

    // Upper counter bytes come from the snapshot taken on the low-byte read.
    always_comb begin
        io_rd_data = 8'h00;
        if (is_rd && is_io) begin
            case (io_ofs)
                IO_UART_OFS:        io_rd_data = rx_empty ? 8'h00 : rx_dout;
                IO_CLK_OFS:         io_rd_data = cycle_cnt[7:0];
                IO_CLK_OFS + 3'd1:  io_rd_data = snap[7:0];
                IO_CLK_OFS + 3'd2:  io_rd_data = snap[15:8];
                IO_CLK_OFS + 3'd3:  io_rd_data = snap[23:16];
                default:            io_rd_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ram_sel_q      <= 1'b0;
            io_q           <= 8'h00;
            cycle_cnt      <= 32'd0;
            snap           <= 24'd0;
            program_stop   <= 1'b0;
            tx_overflow    <= 1'b0;
            io_buffer_full <= 1'b0;
        end else begin
            ram_sel_q      <= is_rd && (region == REGION_RAM);
            io_q           <= io_rd_data;
            cycle_cnt      <= cycle_cnt + 32'd1;
            if (clk_lo_rd) snap <= cycle_cnt[31:8];
            if (stop_wr) program_stop <= 1'b1;
            if (tx_push_req && tx_full && !tx_pop) tx_overflow <= 1'b1;
            io_buffer_full <= (tx_next_count >= TX_FULL_THRESH);
        end
    end

    assign mem_din = ram_sel_q ? ram_q : io_q;

    assign unused_bits = ^{mem_a[31:18], rx_full, rx_count};

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: RAM, decode holes, UART FIFOs,
// cycle counter snapshot, program stop and mid-operation reset.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        program_stop;
    logic        tx_overflow;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  tx_exp_q[$];
    logic [7:0]  rx_model[$];
    logic [7:0]  ram_model [int];
    logic [16:0] rnd_addr[$];

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .program_stop   (program_stop),
        .tx_overflow    (tx_overflow)
    );

    // Clock and watchdog
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, optionally queue the expected mem_din, compare after the edge.
    task automatic bus(input logic wr, input logic [31:0] a, input logic [7:0] d,
                       input logic chk, input logic [7:0] exp, input string tag);
        logic [7:0] e;
        mem_wr   = wr;
        mem_a    = a;
        mem_dout = d;
        if (chk) exp_q.push_back(exp);
        @(posedge clk_in);
        #1;
        if (chk) begin
            e = exp_q.pop_front();
            check_val(tag, mem_din, e);
        end
        mem_wr   = 1'b0;
        mem_a    = 32'h0;
        mem_dout = 8'h00;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(1'b0, 32'h0, 8'h00, 1'b0, 8'h00, "idle");
    endtask

    task automatic ram_write(input logic [16:0] a, input logic [7:0] d);
        ram_model[int'(a)] = d;
        bus(1'b1, {15'b0, a}, d, 1'b1, 8'h00, "wr_din_zero");
    endtask

    task automatic ram_read(input logic [16:0] a);
        bus(1'b0, {15'b0, a}, 8'h00, 1'b1, ram_model[int'(a)], "ram_rd");
    endtask

    task automatic tx_write(input logic [7:0] d, input logic accept);
        if (accept && d != 8'h00) tx_exp_q.push_back(d);
        bus(1'b1, 32'h0003_0000, d, 1'b0, 8'h00, "tx_wr");
    endtask

    task automatic uart_read();
        logic [7:0] e;
        e = (rx_model.size() != 0) ? rx_model.pop_front() : 8'h00;
        if (rx_valid && rx_model.size() < 8) rx_model.push_back(rx_data);
        bus(1'b0, 32'h0003_0000, 8'h00, 1'b1, e, "rx_rd");
    endtask

    task automatic rx_push(input logic [7:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        if (rx_model.size() < 8) rx_model.push_back(d);
        bus(1'b0, 32'h0, 8'h00, 1'b0, 8'h00, "idle");
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        rx_model.delete();
    endtask

    // TX scoreboard: every accepted UART byte must match the oldest expected byte.
    always @(negedge clk_in) begin
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            check_val("tx_expected_pending", tx_exp_q.size() != 0, 1);
            if (tx_exp_q.size() != 0) check_val("tx_data", tx_data, tx_exp_q.pop_front());
        end
    end

    initial begin
        rst_in   = 1'b1;
        mem_a    = 32'h0;
        mem_dout = 8'h00;
        mem_wr   = 1'b0;
        tx_ready = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        check_val("rst_mem_din", mem_din, 0);
        check_val("rst_tx_valid", tx_valid, 0);
        check_val("rst_io_full", io_buffer_full, 0);
        check_val("rst_stop", program_stop, 0);
        check_val("rst_overflow", tx_overflow, 0);
        rst_in = 1'b0;

        // RAM init pattern and round-trip
        for (int i = 0; i < 32; i++) ram_write(17'(i), 8'(i * 7 + 3));
        ram_write(17'h00010, 8'h5A);
        ram_read(17'h00010);
        ram_read(17'h00011);
        ram_write(17'h00012, 8'hC6);
        ram_read(17'h00012);
        ram_read(17'h1FFFF == 17'h1FFFF ? 17'h0001F : 17'h0);

        for (int i = 0; i < 16; i++) begin
            logic [16:0] a;
            a = 17'($urandom_range(0, 17'h1FFFF));
            rnd_addr.push_back(a);
            ram_write(a, 8'($urandom_range(0, 255)));
        end
        foreach (rnd_addr[i]) ram_read(rnd_addr[i]);

        // Unmapped region and undefined IO offsets
        bus(1'b1, 32'h0002_0010, 8'hEE, 1'b1, 8'h00, "unmapped_wr_din");
        bus(1'b0, 32'h0002_0010, 8'h00, 1'b1, 8'h00, "unmapped_rd");
        ram_read(17'h00010);
        bus(1'b0, 32'h0003_0001, 8'h00, 1'b1, 8'h00, "io_ofs1_rd");
        bus(1'b0, 32'h0003_0003, 8'h00, 1'b1, 8'h00, "io_ofs3_rd");
        bus(1'b1, 32'h0003_0001, 8'h99, 1'b0, 8'h00, "io_ofs1_wr");
        bus(1'b1, 32'h0003_0002, 8'h98, 1'b0, 8'h00, "io_ofs2_wr");
        check_val("undef_wr_no_stop", program_stop, 0);

        // UART TX with a zero byte in the middle
        tx_write(8'h41, 1'b1);
        tx_write(8'h00, 1'b1);
        tx_write(8'h42, 1'b1);
        idle(4);
        check_val("tx_drained", tx_exp_q.size(), 0);
        check_val("tx_idle_valid", tx_valid, 0);

        // TX fill with the UART stalled
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tx_write(8'(8'h60 + i), i <= 8);
            if (i == 5) check_val("io_full_at5", io_buffer_full, 0);
            if (i == 6) check_val("io_full_at6", io_buffer_full, 1);
            if (i == 8) check_val("ovf_at8", tx_overflow, 0);
            if (i == 9) check_val("ovf_at9", tx_overflow, 1);
        end
        check_val("tx_head_valid", tx_valid, 1);
        check_val("tx_head_data", tx_data, 8'h61);
        tx_ready = 1'b1;
        idle(10);
        check_val("tx_full_drained", tx_exp_q.size(), 0);
        check_val("tx_full_idle_valid", tx_valid, 0);
        check_val("io_full_cleared", io_buffer_full, 0);
        check_val("ovf_sticky", tx_overflow, 1);

        // UART RX
        uart_read();
        rx_push(8'h37);
        uart_read();
        uart_read();
        for (int i = 0; i < 10; i++) rx_push(8'($urandom_range(1, 255)));
        rx_valid = 1'b1;
        rx_data  = 8'hC3;
        uart_read();
        for (int i = 0; i < 9; i++) uart_read();

        // Cycle counter and coherent snapshot
        do_reset();
        check_val("rst_overflow_clr", tx_overflow, 0);
        idle(300);
        bus(1'b0, 32'h0003_0004, 8'h00, 1'b1, 8'h2C, "clk_b0");
        bus(1'b0, 32'h0003_0005, 8'h00, 1'b1, 8'h01, "clk_b1");
        bus(1'b0, 32'h0003_0006, 8'h00, 1'b1, 8'h00, "clk_b2");
        bus(1'b0, 32'h0003_0007, 8'h00, 1'b1, 8'h00, "clk_b3");
        do_reset();
        idle(511);
        bus(1'b0, 32'h0003_0004, 8'h00, 1'b1, 8'hFF, "clk_snap_b0");
        bus(1'b0, 32'h0003_0005, 8'h00, 1'b1, 8'h01, "clk_snap_b1");
        bus(1'b0, 32'h0003_0006, 8'h00, 1'b1, 8'h00, "clk_snap_b2");

        // Program stop, then reset in the middle of TX/RX activity
        bus(1'b1, 32'h0003_0004, 8'h01, 1'b1, 8'h00, "stop_wr_din");
        check_val("stop_set", program_stop, 1);
        idle(2);
        check_val("stop_sticky", program_stop, 1);
        tx_ready = 1'b0;
        tx_write(8'hA1, 1'b0);
        tx_write(8'hA2, 1'b0);
        tx_write(8'hA3, 1'b0);
        rx_push(8'h11);
        rx_push(8'h22);
        check_val("pre_rst_tx_valid", tx_valid, 1);
        mem_a  = 32'h0000_0010;
        mem_wr = 1'b0;
        do_reset();
        check_val("mid_rst_mem_din", mem_din, 0);
        check_val("mid_rst_stop", program_stop, 0);
        check_val("mid_rst_tx_valid", tx_valid, 0);
        check_val("mid_rst_io_full", io_buffer_full, 0);
        mem_a    = 32'h0;
        tx_ready = 1'b1;
        idle(5);
        bus(1'b0, 32'h0003_0004, 8'h00, 1'b1, 8'h05, "clk_restart_b0");
        bus(1'b0, 32'h0003_0005, 8'h00, 1'b1, 8'h00, "clk_restart_b1");
        uart_read();
        ram_read(17'h00010);
        ram_read(17'h00011);
        check_val("final_tx_q_empty", tx_exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
